// File: rtl/sub_share_pkg.sv
// Shared definitions for the shared sign-magnitude subtractor slice.
// Provides default number format, the saturation magnitude and an
// ID-width helper used by the arbiter and the top level.
package sub_share_pkg;

    localparam int DEF_FRAC_BITS = 6;
    localparam int DEF_INT_BITS  = 5;
    localparam int DEF_WIDTH     = 1 + DEF_INT_BITS + DEF_FRAC_BITS;

    // Largest representable magnitude for the default width
    localparam int MAX_MAG = (2 ** (DEF_WIDTH - 1)) - 1;

    // Width of a requester index; never less than one bit
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter with a one-hot grant.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   valid [N]   : request lines
//   en          : grant enable; grant is all zero when low
//   grant [N]   : one-hot grant (only when en and some valid)
//   grant_idx   : index of the winning request (meaningful when grant != 0)
// The search starts one past the last accepted grant, so the most recently
// served requester has lowest priority next time.
module rr_arbiter
    import sub_share_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = id_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  valid,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            idx;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && valid[idx]) begin
                found     = 1'b1;
                grant_idx = IW'(idx);
            end
        end
        grant = '0;
        if (en && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Reset to N-1 so requester 0 is searched first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IW'(N - 1);
        end else if (en && found) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/sub_fixed.sv
// Saturating sign-magnitude subtractor, diff = a - b (combinational).
// Ports:
//   a, b     : sign-magnitude operands (MSB is sign)
//   diff     : saturated sign-magnitude result, never negative zero
//   overflow : result magnitude was clamped to the maximum
module sub_fixed #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             overflow
);

    localparam int MW = WIDTH - 1;

    logic          sa, sb, sign;
    logic [MW-1:0] ma, mb, mag;
    logic [MW:0]   sum;

    always_comb begin
        sa       = a[WIDTH-1];
        sb       = b[WIDTH-1];
        ma       = a[MW-1:0];
        mb       = b[MW-1:0];
        sum      = '0;
        sign     = 1'b0;
        mag      = '0;
        overflow = 1'b0;
        if (sa == sb) begin
            sum = (ma >= mb) ? ({1'b0, ma} - {1'b0, mb}) : ({1'b0, mb} - {1'b0, ma});
            // Both negative: a >= b exactly when |a| <= |b|
            sign = sa ? (ma > mb) : (ma < mb);
        end else begin
            sum  = {1'b0, ma} + {1'b0, mb};
            sign = sa;
        end
        // The carry bit is set exactly when the magnitude exceeds the maximum
        if (sum[MW]) begin
            mag      = '1;
            overflow = 1'b1;
        end else begin
            mag = sum[MW-1:0];
        end
        if (mag == '0) begin
            sign = 1'b0;
        end
        diff = {sign, mag};
    end

endmodule

// File: rtl/sub_share_arbiter.sv
// One saturating subtractor shared among N_REQ requesters.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot)
//   req_a, req_b        : flattened operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/ready    : result handshake
//   resp_id             : requester that produced the result
//   resp_diff           : saturated a - b
//   resp_overflow       : magnitude was clamped
//   ovf_count           : saturating count of accepted overflowed results
module sub_share_arbiter
    import sub_share_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int FRAC_BITS = DEF_FRAC_BITS,
    parameter  int INT_BITS  = DEF_INT_BITS,
    parameter  int WIDTH     = 1 + INT_BITS + FRAC_BITS,
    parameter  int CNT_W     = 16,
    localparam int ID_W      = id_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [WIDTH-1:0]       resp_diff,
    output logic                   resp_overflow,
    output logic [CNT_W-1:0]       ovf_count
);

    logic             can_issue;
    logic             accept;
    logic [ID_W-1:0]  grant_idx;
    logic [WIDTH-1:0] op_a, op_b, diff;
    logic             ovf;

    // Output register is empty or being drained this cycle
    assign can_issue = !resp_valid || resp_ready;
    assign accept    = |req_ready;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid),
        .en        (can_issue),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                op_a = req_a[i*WIDTH +: WIDTH];
                op_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    sub_fixed #(.WIDTH(WIDTH)) u_sub (
        .a        (op_a),
        .b        (op_b),
        .diff     (diff),
        .overflow (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid    <= 1'b0;
            resp_id       <= '0;
            resp_diff     <= '0;
            resp_overflow <= 1'b0;
        end else if (accept) begin
            // Also covers drain-and-reload in the same edge
            resp_valid    <= 1'b1;
            resp_id       <= grant_idx;
            resp_diff     <= diff;
            resp_overflow <= ovf;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (resp_valid && resp_ready && resp_overflow && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: doc/sub_share_arbiter.md
Name: sub_share_arbiter

Overview:
- Shares one saturating sign-magnitude fixed-point subtractor among N_REQ requesters, e.g. the sigmoid and gate units of the LSTM cell.
- A round-robin arbiter selects one valid request per cycle and computes diff = a - b.
- The result is registered with the requester ID behind a valid/ready output handshake.
- Also keeps a saturating count of overflowed results for debug.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 12, operand/result width: 1 sign + INT_BITS + FRAC_BITS, sign-magnitude.
- FRAC_BITS, 6, fractional bits (documentation only; the arithmetic is format-agnostic).
- INT_BITS, 5, integer bits.
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; a transfer occurs when valid & ready.
- req_a  in  N_REQ*WIDTH  flattened minuends; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  flattened subtrahends, same packing.
- resp_valid  out  1  result register holds valid data.
- resp_ready  in  1  downstream accepts the result.
- resp_id  out  $clog2(N_REQ)  index of the requester that produced the result.
- resp_diff  out  WIDTH  saturated sign-magnitude a - b.
- resp_overflow  out  1  magnitude was saturated.
- ovf_count  out  CNT_W  number of accepted results with overflow=1; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - resp_valid, resp_id, resp_diff, resp_overflow and ovf_count all go to 0.
  - The round-robin pointer is set to N_REQ-1, so requester 0 has first priority.
- can_issue = !resp_valid | resp_ready. The output register is empty, or it is drained in the same cycle.
- Grant (combinational):
  - Search req_valid starting at (ptr+1) mod N_REQ, wrapping; the first set bit wins.
  - req_ready is one-hot: the granted bit only, and only when can_issue=1. Otherwise req_ready is all zero.
  - req_ready never depends on req_a or req_b. It may depend on req_valid.
- Requester rules:
  - Requesters hold valid, a and b stable until accepted.
  - A requester may drop valid only after its transfer.
- On an accepted grant g at a clock edge:
  - The result register loads diff, overflow and id=g, and resp_valid goes to 1.
  - ptr is set to g.
  - Latency is 1 cycle from acceptance to resp_valid.
  - Throughput is 1 result per cycle while resp_ready=1.
- No grant while can_issue=1:
  - If resp_ready=1 and resp_valid=1, resp_valid goes to 0.
  - ptr is unchanged.
- resp_valid=1 and resp_ready=0: all output fields hold; no request is accepted.
- Simultaneous drain and issue: the new result replaces the old one in the same edge, with no bubble.
- ovf_count increments when resp_valid & resp_ready & resp_overflow, and saturates at 2^CNT_W-1.
- Arithmetic, with MAX_MAG = 2^(WIDTH-1)-1:
  - Operate on magnitudes |a| and |b| with one extra bit.
  - Equal signs: subtract the smaller magnitude from the larger. The sign is 0 if the minuend's effective value ≥ the subtrahend's, else 1.
  - Differing signs: add the magnitudes; the result takes sign(a).
  - If the magnitude exceeds MAX_MAG, output MAX_MAG and set overflow=1.
  - A zero magnitude forces sign 0, so negative zero is never output. A -0 input is treated as magnitude 0.
- Reset asserted mid-transfer aborts the transfer. A pending result is discarded, and the pointer returns to N_REQ-1.

Decomposition:
- Package sub_share_pkg holds:
  - the default WIDTH, FRAC_BITS and INT_BITS;
  - MAX_MAG;
  - an ID_W = $clog2(N_REQ) helper function.
- Sub-module rr_arbiter (N parameter) handles the rotating-priority one-hot grant and pointer update, with inputs valid, en and clk/rst_n. It is reusable by other shared LSTM resources.
- The subtraction datapath instantiates the team's existing saturating sign-magnitude subtractor, sub_fixed, unchanged.

Test Plan:
- Basic subtract: req0 a=0x0C0 (+3.0), b=0x040 (+1.0), resp_ready=1 -> next cycle resp_valid=1, id=0, diff=0x080, overflow=0. Swapping the operands gives diff=0x880 (-2.0).
- Saturation and zero:
  - a=0x7FF, b=0x840 (-1.0) -> diff=0x7FF, overflow=1, ovf_count=1 after the handshake.
  - a=0x840, b=0x840 -> diff=0x000, overflow=0.
  - a=0x800, b=0x000 -> diff=0x000.
- Fairness: all four req_valid held high, resp_ready=1 -> resp_id sequence 0,1,2,3,0,1 with one result per cycle. Each requester sees exactly one req_ready pulse per 4 cycles.
- Backpressure: resp_valid=1 with resp_ready=0 for 5 cycles -> outputs are stable and req_ready=0. When resp_ready rises, the old result drains and the next granted result loads in the same edge.
- Sparse and pointer: only req2 valid, then req1 and req3 valid -> grants are 2 then 3 (search starts after 2), then 1.
- Reset mid-operation: assert rst_n=0 while resp_valid=1 and ovf_count=7 -> all outputs are 0 immediately (asynchronous). After release, the first grant among all-valid requesters is 0.
